// File: rtl/bus_req_arbiter.sv
// -----------------------------------------------------------------------------
// bus_req_arbiter
//
// Shares one request/acknowledge bus between NREQ requesters. A pending
// requester is picked round-robin. The arbiter then drives a single-cycle
// bus_req pulse with that requester's data and waits for bus_ack. When the
// transaction ends, it returns a done pulse (acknowledged) or an err pulse
// (timed out) to the granted requester. All outputs are registered.
//
// Ports
//   clk        in   clock, all logic on posedge
//   reset_l    in   asynchronous active-low reset, synchronous release
//   req_valid  in   [NREQ]     requester i has a pending transaction
//   req_data   in   [NREQ*DW]  requester i data at [i*DW +: DW]
//   req_done   out  [NREQ]     one-cycle pulse: transaction acknowledged
//   req_err    out  [NREQ]     one-cycle pulse: transaction timed out
//   bus_req    out             one-cycle request pulse to the target
//   bus_data   out  [DW]       data of the current transaction
//   bus_ack    in              one-cycle acknowledge from the target
//   grant_id   out  [clog2(NREQ)]  current or last granted requester
//   busy       out             high while issuing or waiting
//   stray_ack  out             one-cycle pulse: bus_ack seen while idle
// -----------------------------------------------------------------------------
module bus_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_done,
    output logic [NREQ-1:0]          req_err,
    output logic                     bus_req,
    output logic [DW-1:0]            bus_data,
    input  logic                     bus_ack,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     stray_ack
);

    localparam int unsigned IW = $clog2(NREQ);
    // The timer counts completed WAIT cycles. It needs at least one bit even
    // when TIMEOUT is 0 and the timer is never compared.
    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [IW-1:0]     grant_d;
    logic [DW-1:0]     data_d;
    logic              bus_req_d;
    logic              busy_d;
    logic              stray_d;
    logic [NREQ-1:0]   done_d;
    logic [NREQ-1:0]   err_d;

    // Round-robin pick. The search starts just above the last finished
    // grant and wraps, so the requester served last has the lowest priority.
    logic              pick_found;
    logic [IW-1:0]     pick_idx;

    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        grant_d   = grant_id;
        data_d    = bus_data;
        bus_req_d = 1'b0;
        stray_d   = 1'b0;
        done_d    = '0;
        err_d     = '0;

        unique case (state_q)
            S_IDLE: begin
                // An ack with no transaction in flight is only reported.
                stray_d = bus_ack;
                if (pick_found) begin
                    grant_d   = pick_idx;
                    data_d    = req_data[pick_idx*DW +: DW];
                    bus_req_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                timer_d = '0;
                // An ack in the request cycle itself completes the
                // transaction without entering WAIT.
                if (bus_ack) begin
                    done_d[grant_id] = 1'b1;
                    ptr_d            = grant_id;
                    state_d          = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // An ack takes priority over a timeout in the same cycle.
                if (bus_ack) begin
                    done_d[grant_id] = 1'b1;
                    ptr_d            = grant_id;
                    state_d          = S_IDLE;
                end else if (TIMEOUT != 0 && timer_q == T_LAST) begin
                    err_d[grant_id] = 1'b1;
                    ptr_d           = grant_id;
                    state_d         = S_IDLE;
                end else if (timer_q != '1) begin
                    // Saturate so an unbounded wait never wraps the timer.
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= S_IDLE;
            ptr_q     <= IW'(NREQ - 1);
            timer_q   <= '0;
            grant_id  <= '0;
            bus_data  <= '0;
            bus_req   <= 1'b0;
            busy      <= 1'b0;
            stray_ack <= 1'b0;
            req_done  <= '0;
            req_err   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge regardless of statement order.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            grant_id  <= grant_d;
            bus_data  <= data_d;
            bus_req   <= bus_req_d;
            busy      <= busy_d;
            stray_ack <= stray_d;
            req_done  <= done_d;
            req_err   <= err_d;
        end
    end

endmodule

// File: doc/bus_req_arbiter.md
Name: bus_req_arbiter

Overview:
- Shares the single request/acknowledge bus (bus_req, bus_ack, bus_data) between NREQ requesters.
- Picks one pending requester by round-robin and drives a single-cycle bus_req pulse with its data, then waits for bus_ack.
- Reports completion or timeout back to the granted requester.
- Sits between requester blocks and the bus target; one instance per bus.

Parameters:
- NREQ, 4, number of requesters (2..16)
- DW, 32, bus_data width
- TIMEOUT, 15, max WAIT cycles before abort (0 = no timeout, wait forever)

Ports:
- clk  in  1  clock, all logic on posedge
- reset_l  in  1  asynchronous active-low reset
- req_valid  in  NREQ  bit i = requester i has a pending transaction; held until its done/err pulse
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW]
- req_done  out  NREQ  single-cycle pulse: requester i's transaction acknowledged
- req_err  out  NREQ  single-cycle pulse: requester i's transaction timed out
- bus_req  out  1  single-cycle request pulse to target
- bus_data  out  DW  data for current transaction, stable ISSUE through WAIT
- bus_ack  in  1  single-cycle acknowledge from target
- grant_id  out  clog2(NREQ)  index of current or last granted requester
- busy  out  1  high in ISSUE and WAIT
- stray_ack  out  1  single-cycle pulse: bus_ack seen in IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; rr pointer=NREQ-1 so requester 0 has first priority; timer=0.
- All outputs are registered.
- IDLE: if any req_valid bit set, select the first set bit searching from ptr+1 upward, mod NREQ. Latch req_data slice into bus_data, set grant_id, go ISSUE. bus_req=1 in the next cycle. Latency valid->bus_req = 1 cycle.
- ISSUE: lasts exactly one cycle with bus_req=1. Next state WAIT; bus_req returns to 0. timer cleared to 0.
- WAIT: bus_req=0; bus_data and grant_id held.
  - bus_ack=1: pulse req_done[grant_id] the following cycle, ptr<=grant_id, go IDLE.
  - Else timer+1. When TIMEOUT!=0 and timer reaches TIMEOUT-1 with no ack: pulse req_err[grant_id] the following cycle, ptr<=grant_id, go IDLE.
  - With TIMEOUT!=0, WAIT lasts at most TIMEOUT cycles.
- Ack during ISSUE cycle: accepted as the acknowledge. done pulse in the cycle after ISSUE; WAIT is skipped (state goes to IDLE).
- Ack in IDLE: ignored for handshake; stray_ack pulses the next cycle.
- Ack coincident with timeout expiry: ack wins, done pulses, no err.
- Minimum one IDLE cycle between transactions, so bus_req pulses are never adjacent.
- req_valid of the granted requester dropping mid-transaction: ignored; the transaction completes normally.
- req_valid of other requesters: sampled only in IDLE.
- Only one done or err bit is ever set in a cycle; done and err are never set together.
- timer width: clog2(TIMEOUT+1), min 1. Saturates, never wraps.
- reset_l asserted mid-transaction: immediate return to reset values. No done or err pulse is issued for the aborted transaction.

Test Plan:
- Single request: req_valid=4'b0001, req_data[31:0]=32'hfeed, target acks 2 cycles after bus_req -> bus_req pulse 1 cycle after valid, bus_data=32'hfeed, grant_id=0, req_done=4'b0001 for exactly 1 cycle, busy low after.
- Round-robin: req_valid=4'b1111 held, target acks each request after 1 cycle -> grant order 0,1,2,3,0 and each bus_req pulse separated by at least 1 low cycle.
- Timeout: TIMEOUT=15, req_valid=4'b0100, no ack -> bus_req once, req_err=4'b0100 pulse 16 cycles after bus_req, no req_done, next grant searches from requester 3.
- Boundary: ack on the 15th WAIT cycle -> req_done, not req_err. Ack in the ISSUE cycle -> req_done next cycle.
- Stray ack: bus_ack=1 with req_valid=0 -> stray_ack pulse 1 cycle, state stays IDLE, no bus_req.
- Reset mid-WAIT: reset_l low for 1 cycle while requester 2 waits -> bus_req, busy, done, err all 0; after release with req_valid=4'b0100 still high, requester 2 is re-granted first.
